// File: rtl/uart_rx_frame.sv
// UART receiver: 16x oversampled, majority-voted 8-N/E-2 frame decoder with a small output FIFO.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int CLK_DIV    = 325,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef UART_RX_PARITY_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP1     = 3'd4;
  localparam logic [2:0] S_STOP2     = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE = 3'd6;

  logic               rx_meta_q, rx_meta_d;
  logic               rx_sync_q, rx_sync_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         ph_q, ph_d;
  logic [1:0]         smp_q, smp_d;
  logic [2:0]         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         data_q, data_d;
  logic               perr_q, perr_d;
  logic               push_q, push_d;
  logic [ENTRY_W-1:0] push_entry_q, push_entry_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic tick, decide, maj, pop, full, push_ok;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    ph_d         = ph_q;
    smp_d        = smp_q;
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    perr_d       = perr_q;
    push_d       = 1'b0;
    push_entry_d = push_entry_q;
    frame_err_d  = 1'b0;

    tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    decide    = tick && (ph_q == 4'd9);
    // Bit value is the 2-of-3 vote over the samples taken at phases 7, 8 and 9.
    maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

    if (tick) begin
      ph_d = ph_q + 4'd1;
      if (ph_q == 4'd7) smp_d[0] = rx_sync_q;
      if (ph_q == 4'd8) smp_d[1] = rx_sync_q;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && !rx_sync_q) begin
          state_d = S_START;
          ph_d    = 4'd0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (decide) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          data_d[idx_q] = maj;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_d  = (maj != ^data_q);
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (decide) begin
          if (!maj) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end else begin
            state_d = S_STOP2;
          end
        end
      end
      S_STOP2: begin
        if (decide) begin
          if (!maj) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end else begin
            push_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            push_entry_d = {perr_q, data_q};
`else
            push_entry_d = data_q;
`endif
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) reports once, then waits for the line to recover.
        if (tick && rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    pop       = valid_q && rx_ready;
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok   = push_q && (!full || pop);
    overrun_d = push_q && full && !pop;
    wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    head_d  = head_q;
    // Bypass the write when the new head is the slot being filled this cycle.
    if (count_d != '0) begin
      head_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? push_entry_q : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      div_cnt_q    <= '0;
      ph_q         <= '0;
      smp_q        <= '0;
      state_q      <= S_IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      perr_q       <= 1'b0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      head_q       <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      div_cnt_q    <= div_cnt_d;
      ph_q         <= ph_d;
      smp_q        <= smp_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      perr_q       <= perr_d;
      push_q       <= push_d;
      push_entry_q <= push_entry_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy guarantees no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_q;
  end

  assign rx_data     = head_q[7:0];
`ifdef UART_RX_PARITY_EN
  assign rx_perr     = head_q[8];
`else
  assign rx_perr     = 1'b0;
`endif
  assign rx_valid    = valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = busy_q;

endmodule
